// File: rtl/gpr_pkg.sv
// Shared constants and types for the multi-ported general-purpose register file.
package gpr_pkg;

    localparam int DW_DEF       = 32;
    localparam int AW_DEF       = 5;
    localparam int REG_ZERO     = 0;
    localparam int FLAG_REG_DEF = 30;

    typedef logic [AW_DEF-1:0] regAddr_t;
    typedef logic [DW_DEF-1:0] regData_t;

endpackage

// File: rtl/gpr_scoreboard.sv
// Pending late-write scoreboard: one busy bit per register plus a registered popcount.
module gpr_scoreboard
    import gpr_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issueEn,
    input  logic [AW-1:0]       issueAddr,
    input  logic                retireEn,
    input  logic [AW-1:0]       retireAddr,
    output logic [2**AW-1:0]    busy,
    output logic [AW:0]         busyCnt
);

    localparam logic [AW-1:0] zeroAddr = AW'(REG_ZERO);

    logic [2**AW-1:0] busyNext;
    logic [AW:0]      cntNext;

    // Issue is applied after retire so a same-cycle issue to the retiring register keeps it busy.
    always_comb begin
        busyNext = busy;
        if (retireEn) begin
            busyNext[retireAddr] = 1'b0;
        end
        if (issueEn && issueAddr != zeroAddr) begin
            busyNext[issueAddr] = 1'b1;
        end
    end

    always_comb begin
        cntNext = '0;
        for (int i = 0; i < 2**AW; i++) begin
            cntNext = cntNext + (AW+1)'(busyNext[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= '0;
            busyCnt <= '0;
        end else begin
            busy    <= busyNext;
            busyCnt <= cntNext;
        end
    end

endmodule

// File: rtl/gpr_mp.sv
// Two-read / two-write register file with an overflow-flag write path and
// optional same-cycle forwarding. Every enable is accepted the cycle it is high.
module gpr_mp
    import gpr_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF,
    parameter int FLAG_REG = FLAG_REG_DEF,
    parameter int BYPASS   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   ra_addr,
    input  logic [AW-1:0]   rb_addr,
    output logic [DW-1:0]   ra_data,
    output logic [DW-1:0]   rb_data,
    output logic            ra_busy,
    output logic            rb_busy,
    input  logic            we0,
    input  logic [AW-1:0]   waddr0,
    input  logic [DW-1:0]   wdata0,
    input  logic            we1,
    input  logic [AW-1:0]   waddr1,
    input  logic [DW-1:0]   wdata1,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_addr,
    input  logic            ovf_en,
    input  logic            ovf,
    output logic [AW:0]     busy_cnt
);

    localparam logic [AW-1:0] zeroAddr = AW'(REG_ZERO);
    localparam logic [AW-1:0] flagAddr = AW'(FLAG_REG);

    logic [DW-1:0]    regs [2**AW];
    logic [2**AW-1:0] busy;
    logic [DW-1:0]    flagWord;
    logic [AW-1:0]    rdAddr [2];
    logic [DW-1:0]    rdData [2];
    logic             rdBusy [2];

    assign flagWord = {{(DW-1){1'b0}}, ovf};

    gpr_scoreboard #(.AW(AW)) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .issueEn    (issue_en),
        .issueAddr  (issue_addr),
        .retireEn   (we1),
        .retireAddr (waddr1),
        .busy       (busy),
        .busyCnt    (busy_cnt)
    );

    // Later non-blocking assignments win, giving flag > W1 > W0 on a shared address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2**AW; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (we0 && waddr0 != zeroAddr) begin
                regs[waddr0] <= wdata0;
            end
            if (we1 && waddr1 != zeroAddr) begin
                regs[waddr1] <= wdata1;
            end
            if (ovf_en && flagAddr != zeroAddr) begin
                regs[flagAddr] <= flagWord;
            end
        end
    end

    assign rdAddr[0] = ra_addr;
    assign rdAddr[1] = rb_addr;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdData[p] = regs[rdAddr[p]];
            rdBusy[p] = busy[rdAddr[p]];
            if (BYPASS != 0) begin
                if (we0 && waddr0 == rdAddr[p]) begin
                    rdData[p] = wdata0;
                end
                if (we1 && waddr1 == rdAddr[p]) begin
                    rdData[p] = wdata1;
                    rdBusy[p] = 1'b0;
                end
                if (ovf_en && flagAddr == rdAddr[p]) begin
                    rdData[p] = flagWord;
                end
            end
            if (rdAddr[p] == zeroAddr) begin
                rdData[p] = '0;
                rdBusy[p] = 1'b0;
            end
        end
    end

    assign ra_data = rdData[0];
    assign rb_data = rdData[1];
    assign ra_busy = rdBusy[0];
    assign rb_busy = rdBusy[1];

endmodule
